// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: shared GPIO register map, bus address fields and data width
package gpio_irq_pkg;
  localparam int DATA_N = 8;
  localparam int PERIPH_W = 5;
  typedef logic [PERIPH_W-1:0] periphLogic;
  localparam logic [2:0] OFF_DIR = 3'd0;
  localparam logic [2:0] OFF_OUT = 3'd1;
  localparam logic [2:0] OFF_IN = 3'd2;
  localparam logic [2:0] OFF_OUTSET = 3'd3;
  localparam logic [2:0] OFF_OUTCLR = 3'd4;
  localparam logic [2:0] OFF_IE = 3'd5;
  localparam logic [2:0] OFF_EDGE = 3'd6;
  localparam logic [2:0] OFF_IFR = 3'd7;
  localparam int PORT_LSB = 3;
  localparam int PORT_W = 2;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: per-port pin synchroniser with one extra history stage for rise/fall pulses
module gpio_sync
  import gpio_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [DATA_N-1:0] pin,
  output logic [DATA_N-1:0] synced,
  output logic [DATA_N-1:0] rise,
  output logic [DATA_N-1:0] fall
);
  logic [DATA_N-1:0] stg [SYNC_STAGES];
  logic [DATA_N-1:0] hist;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) stg[k] <= '0;
      hist <= '0;
    end else begin
      stg[0] <= pin;
      for (int k = 1; k < SYNC_STAGES; k++) stg[k] <= stg[k-1];
      hist <= stg[SYNC_STAGES-1];
    end
  assign synced = stg[SYNC_STAGES-1];
  assign rise = synced & ~hist;
  assign fall = ~synced & hist;
endmodule

// File: rtl/gpio_irq.sv
// gpio_irq: multi-port GPIO register file with tristate pins and edge-triggered interrupt flags
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int PORTS = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          bus_we,
  input  logic                          bus_oe,
  input  logic                          periph_sel,
  input  periphLogic                    periph_addr,
  inout  wire logic [DATA_N-1:0]        bus_data,
  inout  wire logic [PORTS*DATA_N-1:0]  io,
  output logic                          irq
);
  logic [2:0] off;
  logic [PORT_W-1:0] idx;
  logic [DATA_N-1:0] rd [4];
  logic [3:0] pend;
  assign off = periph_addr[2:0];
  assign idx = periph_addr[PORT_LSB +: PORT_W];
  for (genvar p = 0; p < 4; p++) begin : g_port
    if (p < PORTS) begin : g_on
      logic [DATA_N-1:0] dir, out, ie, edg, ifr, in_s, rise, fall;
      logic wr;
      assign wr = periph_sel & bus_we & (idx == PORT_W'(p));
      gpio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .n_reset(n_reset),
        .pin    (io[p*DATA_N +: DATA_N]),
        .synced (in_s),
        .rise   (rise),
        .fall   (fall)
      );
      // a W1C clear is applied before the new edge set, so a coincident edge wins
      always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
          dir <= '0;
          out <= '0;
          ie <= '0;
          edg <= '0;
          ifr <= '0;
        end else begin
          if (wr && off == OFF_DIR) dir <= bus_data;
          if (wr) out <= off == OFF_OUT ? bus_data : off == OFF_OUTSET ? out | bus_data : off == OFF_OUTCLR ? out & ~bus_data : out;
          if (wr && off == OFF_IE) ie <= bus_data;
          if (wr && off == OFF_EDGE) edg <= bus_data;
          ifr <= (ifr & ~(wr && off == OFF_IFR ? bus_data : '0)) | (ie & ((rise & edg) | (fall & ~edg)));
        end
      for (genvar i = 0; i < DATA_N; i++) begin : g_pin
        assign io[p*DATA_N+i] = dir[i] ? out[i] : 1'bz;
      end
      assign rd[p] = off == OFF_DIR ? dir : off == OFF_OUT ? out : off == OFF_IN ? in_s :
                     off == OFF_IE ? ie : off == OFF_EDGE ? edg : off == OFF_IFR ? ifr : '0;
      assign pend[p] = |(ifr & ie);
    end else begin : g_off
      assign rd[p] = '0;
      assign pend[p] = 1'b0;
    end
  end
  assign bus_data = periph_sel & bus_oe ? rd[idx] : 'z;
  assign irq = |pend;
endmodule

// File: doc/gpio_irq.md
GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 SHALL have parameter PORTS, default 1: number of DATA_N-bit ports, legal range 1..4.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..3.
REQ-003 SHALL have port clk  input  1  single peripheral clock; all state on its rising edge.
REQ-004 SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port bus_we  input  1  bus write strobe.
REQ-006 SHALL have port bus_oe  input  1  bus read strobe.
REQ-007 SHALL have port periph_sel  input  1  block select.
REQ-008 SHALL have port periph_addr  input  periphLogic  register address: bits [2:0] are the register offset, bits [4:3] are the port index.
REQ-009 SHALL have port bus_data  inout  DATA_N  shared data bus.
REQ-010 SHALL have port io  inout  PORTS*DATA_N  pins; port p occupies bits [p*DATA_N +: DATA_N].
REQ-011 SHALL have port irq  output  1  level interrupt request.

Function
REQ-012 SHALL implement per-port offsets: 0 DIR, 1 OUT, 2 IN, 3 OUTSET, 4 OUTCLR, 5 IE, 6 EDGE (1=rising, 0=falling), 7 IFR.
REQ-013 SHALL drive bus_data only while periph_sel & bus_oe; otherwise bus_data SHALL be high-Z.
REQ-014 SHALL return the register contents on reads of DIR, OUT, IN, IE, EDGE and IFR; reads of OUTSET, OUTCLR, or a port index >= PORTS SHALL return 0.
REQ-015 SHALL write on a rising clk edge with periph_sel & bus_we; writes to IN, or to a port index >= PORTS, SHALL be ignored.
REQ-016 SHALL update OUT on writes: OUTSET gives OUT |= data; OUTCLR gives OUT &= ~data.
REQ-017 SHALL drive pin bit i from OUT[i] when DIR[i]=1; otherwise the pin SHALL be high-Z.
REQ-018 SHALL pass each pin through a SYNC_STAGES flop chain; IN SHALL show the last stage, giving a pin-to-IN latency of SYNC_STAGES cycles.
REQ-019 SHALL detect an edge from the last sync stage compared with one further registered copy, with polarity per EDGE bit.
REQ-020 SHALL set IFR[i] one cycle after IN[i] changes, only if the edge matches EDGE[i] and IE[i]=1.
REQ-021 SHALL treat IFR as write-1-to-clear; writing 0 to a bit SHALL leave it unchanged.
REQ-022 SHALL let set win when a detected edge and a W1C hit the same IFR bit in the same cycle.
REQ-023 SHALL keep IFR bits already set when IE is cleared, while blocking new sets.
REQ-024 SHALL detect edges on output-enabled pins too, since IN reflects the driven level.
REQ-025 SHALL compute irq as the OR over all ports of (IFR & IE), directly from flops with no combinational bus paths.
REQ-026 SHALL detect pulses narrower than one clk period on a best-effort basis only; such pulses are not guaranteed to be seen.

Reset
REQ-027 SHALL, while n_reset=0, clear DIR, OUT, IE, EDGE, IFR, all sync stages and edge history to 0, immediately and without waiting for clk.
REQ-028 SHALL, in reset, leave all io pins high-Z, bus_data high-Z and irq=0.
REQ-029 SHALL raise no IFR bit from post-reset sync fill, because IE resets to 0.
REQ-030 SHALL, on reset asserted mid-access, discard the access with no partial register update.

Structure
REQ-031 SHALL place GPIO register offset constants (DIR..IFR) and the port-index field position in the shared config package/header, alongside DATA_N and periphLogic.
REQ-032 SHALL implement one sub-module, gpio_sync, per port: SYNC_STAGES synchroniser plus edge-history register, with outputs for the synced value and rise/fall pulse vectors.
REQ-033 SHALL keep register decode, IFR logic and tristate control in gpio_irq, built with a generate loop over PORTS.

Verification (DATA_N=8, PORTS=2, SYNC_STAGES=2)
REQ-034 SHALL cover: write port0 DIR=0x0F, OUT=0xA5 -> io[7:0]=zzzz_0101, and reads return DIR=0x0F, OUT=0xA5.
REQ-035 SHALL cover: OUT=0x0F, then OUTSET 0x30, then OUTCLR 0x03 -> OUT reads 0x3C; OUTSET/OUTCLR read 0x00.
REQ-036 SHALL cover: port1 IE=0x01, EDGE=0x01, drive io[8] 0->1 at cycle t -> IN bit0 at t+2, IFR=0x01 at t+3, irq=1; a falling edge sets nothing.
REQ-037 SHALL cover: IFR=0x01 pending, W1C 0x01 in the same cycle as a new rising edge -> IFR stays 0x01; a later W1C 0x01 with no edge -> IFR=0x00, irq=0.
REQ-038 SHALL cover: io all high, release n_reset, wait 5 cycles -> IFR=0 and irq=0 on both ports; read of port index 2 -> 0x00.
REQ-039 SHALL cover: async n_reset pulse between clk edges with DIR=0xFF -> io goes high-Z before the next clk edge.
